// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parallel RGB LCD raster generator producing HSYNC/VSYNC/DE, active pixel
// coordinates and a per-frame selectable RGB565 test pattern, all registered and mutually aligned.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 20,
    parameter int H_BP     = 26,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pat_sel,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic [4:0]  lcd_r,
    output logic [5:0]  lcd_g,
    output logic [4:0]  lcd_b,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W = H_ACTIVE / 8;

    logic [10:0] h_cnt, bar_col;
    logic [9:0]  v_cnt;
    logic [3:0]  bar_idx;
    logic [1:0]  pat_q, pat;
    logic        h_end, v_end, bar_end, de, hs_n, vs_n, fs, grid;
    logic [4:0]  r, b;
    logic [5:0]  g;

    always_comb begin
        h_end   = h_cnt == 11'(H_TOT - 1);
        v_end   = v_cnt == 10'(V_TOT - 1);
        bar_end = bar_col == 11'(BAR_W - 1);
        de      = h_cnt < 11'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
        hs_n    = !(h_cnt >= 11'(H_ACTIVE + H_FP) && h_cnt < 11'(H_ACTIVE + H_FP + H_SYNC));
        vs_n    = !(v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC));
        fs      = h_cnt == 11'd0 && v_cnt == 10'd0;
        // pixel (0,0) already uses the pattern being latched on this edge
        pat     = fs ? pat_sel : pat_q;
        grid    = h_cnt[3:0] == 4'd0 || v_cnt[3:0] == 4'd0;
        // bar index bits map directly to colour: bit1 kills red, bit2 green, bit0 blue
        r = !de ? 5'd0 : pat == 2'd0 ? {5{~bar_idx[1]}} : pat == 2'd1 ? {5{grid}} :
            pat == 2'd2 ? h_cnt[9:5] : 5'd31;
        g = !de ? 6'd0 : pat == 2'd0 ? {6{~bar_idx[2]}} : pat == 2'd1 ? {6{grid}} :
            pat == 2'd2 ? v_cnt[8:3] : 6'd63;
        b = !de ? 5'd0 : pat == 2'd0 ? {5{~bar_idx[0]}} : pat == 2'd1 ? {5{grid}} :
            pat == 2'd3 ? 5'd31 : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_col     <= '0;
            bar_idx     <= '0;
            pat_q       <= '0;
            lcd_hsync   <= 1'b1;
            lcd_vsync   <= 1'b1;
            lcd_de      <= 1'b0;
            lcd_r       <= '0;
            lcd_g       <= '0;
            lcd_b       <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            h_cnt       <= h_end ? 11'd0 : h_cnt + 11'd1;
            if (h_end)
                v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
            bar_col     <= (h_end || bar_end) ? 11'd0 : bar_col + 11'd1;
            bar_idx     <= h_end ? 4'd0 : bar_end ? bar_idx + 4'd1 : bar_idx;
            if (fs)
                pat_q <= pat_sel;
            lcd_hsync   <= hs_n;
            lcd_vsync   <= vs_n;
            lcd_de      <= de;
            lcd_r       <= r;
            lcd_g       <= g;
            lcd_b       <= b;
            pix_x       <= de ? h_cnt : 11'd0;
            pix_y       <= de ? v_cnt : 10'd0;
            frame_start <= fs;
        end
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed/random run of the raster generator against a cycle-count reference
// model; horizontal timing is full size, vertical timing is shortened to keep frames short.
module tb_lcd_timing_gen;
    localparam int HA = 800, HF = 210, HS = 20, HB = 26;
    localparam int VA = 12, VF = 2, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  pat_sel = 2'd0;
    logic        lcd_hsync, lcd_vsync, lcd_de, frame_start;
    logic [4:0]  lcd_r, lcd_b;
    logic [5:0]  lcd_g;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [15:0] rgb;

    int total = 0, bad = 0;
    int n = 0, p = 0;
    logic [1:0] lat = 2'd0;
    int fs_n = -1, de_rise_n = -1, de_run = 0, de_len = 0, hs_run = 0, hs_w = 0, hs_off = 0;
    int vs_cnt = 0, vs_off = 0, de_lines = 0, fs_gap = 0, frm_vs = 0, frm_vs_off = 0;
    int frm_lines = 0, line_per = 0, k = 0, k2 = 0;
    logic prev_de = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;

    assign rgb = {lcd_r, lcd_g, lcd_b};

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .pat_sel(pat_sel),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_rgb(input int h, input int v, input logic [1:0] pt);
        if (!(h < HA && v < VA)) return 16'h0;
        case (pt)
            2'd0:    return BARS[h / (HA / 8)];
            2'd1:    return (h % 16 == 0 || v % 16 == 0) ? 16'hFFFF : 16'h0000;
            2'd2:    return {5'((h / 32) % 32), 6'((v / 8) % 64), 5'd0};
            default: return 16'hFFFF;
        endcase
    endfunction

    // One clock: check every output against the model, then update timing measurements
    task automatic step();
        logic [1:0] ps;
        logic       r, de_e, hs_e, vs_e, fs_e;
        int         h, v;
        ps = pat_sel;
        r  = rst;
        @(posedge clk);
        #1;
        n++;
        if (r) begin
            chk("rst_sync", {lcd_hsync, lcd_vsync, lcd_de, frame_start}, 4'b1100);
            chk("rst_pix", {pix_x, pix_y}, 0);
            chk("rst_rgb", rgb, 0);
            p = 0; fs_n = -1; de_rise_n = -1; de_run = 0; hs_run = 0; vs_cnt = 0; de_lines = 0;
            prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
            return;
        end
        h = p % HT;
        v = (p / HT) % VT;
        fs_e = h == 0 && v == 0;
        if (fs_e) lat = ps;
        de_e = h < HA && v < VA;
        hs_e = !(h >= HA + HF && h < HA + HF + HS);
        vs_e = !(v >= VA + VF && v < VA + VF + VS);
        chk("sync", {lcd_hsync, lcd_vsync, lcd_de, frame_start}, {hs_e, vs_e, de_e, fs_e});
        chk("pix", {pix_x, pix_y}, de_e ? {11'(h), 10'(v)} : 21'd0);
        chk("rgb", rgb, ref_rgb(h, v, lat));
        p = (p + 1) % FT;
        if (frame_start) begin
            if (fs_n >= 0) begin
                fs_gap = n - fs_n; frm_vs = vs_cnt; frm_lines = de_lines; frm_vs_off = vs_off;
            end
            fs_n = n; vs_cnt = 0; de_lines = 0;
        end
        if (lcd_de && !prev_de) begin
            if (de_rise_n >= 0) line_per = n - de_rise_n;
            de_rise_n = n;
            de_lines++;
        end
        if (lcd_de) de_run++;
        else if (prev_de) begin de_len = de_run; de_run = 0; end
        if (!lcd_hsync) begin
            if (prev_hs) hs_off = n - de_rise_n;
            hs_run++;
        end else if (!prev_hs) begin
            hs_w = hs_run; hs_run = 0;
        end
        if (!lcd_vsync) begin
            if (prev_vs) vs_off = n - fs_n;
            vs_cnt++;
        end
        prev_de = lcd_de; prev_hs = lcd_hsync; prev_vs = lcd_vsync;
    endtask

    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) step();
    endtask

    initial begin
        run(5);
        rst = 1'b0;
        step();
        chk("first_de_fs", {lcd_de, frame_start}, 2'b11);
        chk("first_xy", {pix_x, pix_y}, 0);
        chk("first_rgb", rgb, 16'hFFFF);
        run(99);
        chk("bar_x99", rgb, 16'hFFFF);
        run(1);
        chk("bar_x100", rgb, 16'hFFE0);
        run(600);
        chk("bar_x700", rgb, 16'h0000);
        run(99);
        chk("bar_x799", {lcd_de, rgb}, 17'h10000);
        run(1);
        chk("blank_rgb", {lcd_de, rgb}, 17'h00000);
        run(3 * HT - 801);
        chk("de_len", de_len, HA);
        chk("hs_off", hs_off, HA + HF);
        chk("hs_w", hs_w, HS);
        chk("line_per", line_per, HT);
        run(3 * HT);
        pat_sel = 2'd3;
        run(150);
        chk("bars_hold", rgb, 16'hFFE0);
        run(FT - 6 * HT - 150);
        step();
        chk("fs1", frame_start, 1'b1);
        chk("solid_next", rgb, 16'hFFFF);
        chk("fs_gap0", fs_gap, FT);
        chk("vs_clks", frm_vs, VS * HT);
        chk("vs_start", frm_vs_off, (VA + VF) * HT);
        chk("de_lines", frm_lines, VA);
        k = $urandom_range(100, FT / 2);
        run(k);
        pat_sel = 2'($urandom);
        k2 = $urandom_range(100, FT / 4);
        run(k2);
        pat_sel = 2'd2;
        run(FT - 1 - k - k2);
        step();
        chk("fs_gap1", fs_gap, FT);
        chk("de_lines1", frm_lines, VA);
        run(9 * HT + 799);
        chk("grad_corner", {pix_x, pix_y, rgb}, {11'd799, 10'd9, 16'hC020});
        run(HT - 299);
        chk("pre_rst_pos", {pix_x, pix_y}, {11'd500, 10'd10});
        rst = 1'b1;
        pat_sel = 2'($urandom);
        step();
        rst = 1'b0;
        step();
        chk("restart_fs", {frame_start, lcd_de}, 2'b11);
        chk("restart_xy", {pix_x, pix_y}, 0);
        run(2 * HT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
